// File: rtl/memory_cycle_stall_pkg.sv
// Shared pipeline definitions for the MEM stage: FSM encoding, data width, the MEM/WB payload.
package memory_cycle_stall_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned DefaultTimeout = 16;

  typedef enum logic {
    StIdle = 1'b0,
    StWait = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic            reg_write;
    logic            result_src;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] read_data;
    logic            bus_err;
  } mem_wb_t;

endpackage

// File: rtl/memory_cycle_stall_if.sv
// Handshaked data-memory port; deasserting req cancels an outstanding access.
interface memory_cycle_stall_if;
  import memory_cycle_stall_pkg::*;

  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rdata;
  logic            ack;

  modport master (output req, output we, output addr, output wdata, input rdata, input ack);
  modport slave  (input req, input we, input addr, input wdata, output rdata, output ack);

endinterface

// File: rtl/memory_cycle_stall_mem_wb_reg.sv
// MEM/WB pipeline register; bubble kills the write-back and error flags but holds the payload.
module mem_wb_reg
  import memory_cycle_stall_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    bubble,
  input  mem_wb_t d,
  output mem_wb_t q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (bubble) begin
      q.reg_write <= 1'b0;
      q.bus_err   <= 1'b0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/memory_cycle_stall.sv
// MEM stage: drives the data-memory handshake, stalls the front of the pipe while waiting,
// and flags misaligned or timed-out accesses into WB.
module memory_cycle_stall
  import memory_cycle_stall_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RegWriteM,
  input  logic                 MemWriteM,
  input  logic                 ResultSrcM,
  input  logic [4:0]           RD_M,
  input  logic [XLEN-1:0]      PCPlus4M,
  input  logic [XLEN-1:0]      WriteDataM,
  input  logic [XLEN-1:0]      ALU_ResultM,
  memory_cycle_stall_if.master dmem,
  output logic                 StallM,
  output logic                 RegWriteW,
  output logic                 ResultSrcW,
  output logic [4:0]           RD_W,
  output logic [XLEN-1:0]      PCPlus4W,
  output logic [XLEN-1:0]      ALU_ResultW,
  output logic [XLEN-1:0]      ReadDataW,
  output logic                 BusErrW,
  output logic [CNT_W-1:0]     ErrCountW
);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic    memop, misaligned, timeout_hit, timeout_abort, done, err;
  mem_wb_t wb_d, wb_q;

  assign memop      = MemWriteM | ResultSrcM;
  assign misaligned = memop & (ALU_ResultM[1:0] != 2'b00);

  // Gated by reset so an access is cancelled the moment reset asserts.
  assign dmem.req   = memop & ~misaligned & rst;
  assign dmem.we    = MemWriteM;
  assign dmem.addr  = ALU_ResultM;
  assign dmem.wdata = WriteDataM;

  assign timeout_hit   = (state_q == StWait) && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign done          = dmem.req & dmem.ack;
  assign timeout_abort = dmem.req & ~dmem.ack & timeout_hit;
  assign StallM        = dmem.req & ~dmem.ack & ~timeout_hit;
  assign err           = misaligned | timeout_abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_cnt_d = err_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (dmem.req && !dmem.ack) begin
          state_d = StWait;
          cnt_d   = CNT_W'(1);
        end
      end
      StWait: begin
        if (!dmem.req || dmem.ack || timeout_hit) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
    if (err && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    wb_d            = '0;
    wb_d.reg_write  = RegWriteM & ~err;
    wb_d.result_src = ResultSrcM;
    wb_d.rd         = RD_M;
    wb_d.pc_plus4   = PCPlus4M;
    wb_d.alu_result = ALU_ResultM;
    wb_d.read_data  = done ? dmem.rdata : '0;
    wb_d.bus_err    = err;
  end

  mem_wb_reg u_mem_wb_reg (
    .clk    (clk),
    .rst    (rst),
    .bubble (StallM),
    .d      (wb_d),
    .q      (wb_q)
  );

  assign RegWriteW   = wb_q.reg_write;
  assign ResultSrcW  = wb_q.result_src;
  assign RD_W        = wb_q.rd;
  assign PCPlus4W    = wb_q.pc_plus4;
  assign ALU_ResultW = wb_q.alu_result;
  assign ReadDataW   = wb_q.read_data;
  assign BusErrW     = wb_q.bus_err;
  assign ErrCountW   = err_cnt_q;

endmodule

// File: doc/memory_cycle_stall.md
Name: memory_cycle_stall

Overview:
- MEM stage of the 5-stage RV32 pipeline; consumes the EX/MEM register outputs and produces the MEM/WB register.
- Drives a handshaked data-memory port that tolerates variable latency, zero-wait ack, and a timeout.
- Raises StallM to the hazard unit while an access is outstanding; inserts a write-back bubble while stalled.
- Flags misaligned and timed-out accesses.

Parameters:
- TIMEOUT, 16: maximum WAIT cycles before an access is aborted. Legal range 2..255.
- CNT_W, 8: width of the timeout counter and of ErrCountW.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous active-low reset
- RegWriteM  in  1  EX/MEM register-write enable
- MemWriteM  in  1  store instruction
- ResultSrcM  in  1  load instruction (1 = write back read data)
- RD_M  in  5  destination register
- PCPlus4M  in  32  PC+4 of the instruction
- WriteDataM  in  32  store data (already forwarded)
- ALU_ResultM  in  32  effective address / ALU result
- dmem_req  out  1  access request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word address (= ALU_ResultM)
- dmem_wdata  out  32  store data
- dmem_rdata  in  32  load data, valid with dmem_ack
- dmem_ack  in  1  completion; may rise in the same cycle as dmem_req
- StallM  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- RegWriteW  out  1  MEM/WB register-write enable
- ResultSrcW  out  1  MEM/WB load select
- RD_W  out  5  MEM/WB destination register
- PCPlus4W  out  32  MEM/WB PC+4
- ALU_ResultW  out  32  MEM/WB ALU result
- ReadDataW  out  32  MEM/WB load data
- BusErrW  out  1  one-cycle pulse with the faulting instruction in WB
- ErrCountW  out  CNT_W  saturating count of errors

Behaviour:
- Reset (rst=0, asynchronous): FSM to IDLE, counter 0. All W outputs, BusErrW and ErrCountW go to 0. dmem_req=0.
- Reset mid-access abandons the access. The memory side must treat deassertion of req as a cancel.
- The access condition is memop = MemWriteM | ResultSrcM.
- Misaligned access (memop & ALU_ResultM[1:0]!=0):
  - dmem_req is not asserted and no stall occurs.
  - At the next edge MEM/WB captures with RegWriteW=0, ReadDataW=0 and BusErrW=1.
  - ErrCountW increments.
- Combinational request outputs:
  - dmem_req = aligned memop while in IDLE or WAIT.
  - dmem_we = MemWriteM, dmem_addr = ALU_ResultM, dmem_wdata = WriteDataM.
- FSM states:
  - IDLE: if dmem_req & !dmem_ack, go to WAIT and set the counter to 1. If dmem_req & dmem_ack, stay in IDLE (zero-wait access).
  - WAIT: dmem_req is held and the inputs stay stable because EX/MEM is frozen.
    - On dmem_ack, go to IDLE.
    - Otherwise, if counter == TIMEOUT-1, abort and go to IDLE.
    - Otherwise increment the counter.
- StallM = dmem_req & !dmem_ack & !(state==WAIT & counter==TIMEOUT-1). StallM is combinational, so an ack removes the stall in the same cycle.
- MEM/WB register, updated at every rising edge:
  - While StallM=1: a bubble is loaded (RegWriteW=0, BusErrW=0). The other fields are don't-care but are held at their previous values.
  - Otherwise the M fields are captured.
  - ReadDataW = dmem_rdata when an ack occurs, else 0.
- Timeout abort cycle:
  - StallM=0 and the instruction advances with RegWriteW=0 and BusErrW=1.
  - ErrCountW increments.
  - A store is considered not performed.
- ErrCountW saturates at all-ones.
- A late ack arriving in IDLE without a request is ignored.
- Latency:
  - Non-memory ops and zero-wait accesses add 0 stall cycles.
  - An N-wait access stalls for N cycles.
  - Timeout stalls for TIMEOUT-1 cycles.

Decomposition:
- Shared pipeline package holds:
  - MEM FSM state encoding (IDLE=1'b0, WAIT=1'b1);
  - the XLEN=32 constant;
  - the default TIMEOUT.
- One natural sub-module, mem_wb_reg: the MEM/WB pipeline register with a bubble input. It is reusable by the hazard unit for flushes.

Test Plan:
- Reset: hold rst=0 with dmem_ack=1 → all outputs 0, dmem_req=0. Release rst → outputs stay 0 until the first edge with valid input.
- ALU op (RegWriteM=1, RD_M=5, ALU_ResultM=0x1234, no memop) → StallM never 1. Next cycle RD_W=5, ALU_ResultW=0x1234, RegWriteW=1.
- Zero-wait load (ResultSrcM=1, addr 0x100, ack same cycle, rdata 0xDEADBEEF) → no stall. Next cycle ReadDataW=0xDEADBEEF, ResultSrcW=1.
- 3-wait store (MemWriteM=1, addr 0x200, wdata 0xA5A5A5A5, ack on 4th req cycle):
  - StallM=1 for exactly 3 cycles and RegWriteW=0 during them.
  - dmem_addr/wdata are stable throughout.
  - One store is seen by the memory model.
- Timeout, TIMEOUT=4, load that is never acked → StallM=1 for 3 cycles. Then BusErrW pulses once, RegWriteW=0, ErrCountW=1, FSM returns to IDLE.
- Misaligned load at 0x102 → dmem_req stays 0, no stall, BusErrW=1 next cycle, ErrCountW increments. Back-to-back misaligned accesses drive ErrCountW to saturation.
